sr_calc_ctrl: RTL and testbench
===============================

Name: sr_calc_ctrl

Overview:
Sequencer between sr_control and the multi-cycle func_calculator. It accepts one HYP-class request at a time and latches its operands and destination register. It pulses calc start, stalls the PC while the calculator is busy, then issues a single-cycle register-file write-back. It replaces the negedge-calcBusy stall logic with a fully synchronous FSM and adds a hang watchdog.

Parameters:
OP_W, 8, calculator operand width
RES_W, 24, calculator result width; zero-extended to 32 on write-back
TIMEOUT, 64, max cycles in WAIT_BUSY+RUN before abort; must be >=2 and fit in CNT_W
CNT_W, 7, watchdog counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  decoded HYP instruction present; held until stall deasserts
req_a  in  OP_W  operand A (rs1 low bits)
req_b  in  OP_W  operand B (srcB low bits)
req_rd  in  5  destination register
stall  out  1  hold PC; combinational
calc_start  out  1  one-cycle start pulse to func_calculator
calc_a  out  OP_W  latched operand A
calc_b  out  OP_W  latched operand B
calc_busy  in  1  func_calculator busy_o
calc_y  in  RES_W  func_calculator y
wb_en  out  1  register-file write enable, one cycle
wb_rd  out  5  write-back address
wb_data  out  32  {(32-RES_W)'b0, result}
err  out  1  sticky watchdog-abort flag

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; calc_a, calc_b, wb_rd, wb_data, cnt = 0; err=0; all pulses 0. Reset mid-operation abandons the request with no write-back. The calculator shares rst.
- States: IDLE, LAUNCH, WAIT_BUSY, RUN, WB.
- IDLE: when req_valid=1, latch req_a, req_b and req_rd, then go to LAUNCH.
- LAUNCH: calc_start=1 for exactly this cycle; cnt=0; go to WAIT_BUSY.
- WAIT_BUSY: when calc_busy=1, go to RUN. Otherwise cnt++.
- RUN: when calc_busy=0, capture calc_y into wb_data and go to WB. Otherwise cnt++.
- Watchdog: in WAIT_BUSY or RUN, when cnt==TIMEOUT-1 and the exit condition is false, go to WB with wb_data=0 and set err=1.
- WB: wb_en=1 if wb_rd!=0, else wb_en=0 (x0 never written); next state IDLE.
- stall = (state==IDLE & req_valid) | (state!=IDLE & state!=WB). Stall drops in WB, so the PC advances on the same edge the register file writes.
- Nominal latency from req_valid to wb_en: 4 + N cycles, where N = cycles calc_busy is high.
- req_valid in any non-IDLE state is ignored. It must be the same held request, guaranteed by stall.
- calc_busy already high in IDLE (stale): not launched until it clears. IDLE→LAUNCH additionally requires calc_busy=0; stall stays asserted meanwhile.
- calc_busy high for one cycle only: RUN is entered and exited normally.
- wb_data is held after WB until the next capture.

Optional Feature:
SR_CALC_MEMO_EN
- Defined: a single-entry memo stores {valid, a, b, y}. It is filled in RUN on normal completion.
- A request in IDLE with memo valid and (req_a, req_b) equal to the stored pair skips directly to WB with the stored y. Latency 1 cycle; no calc_start.
- The memo is invalidated by reset and by watchdog abort.
- Undefined: no memo storage; every request takes the full sequence.

Decomposition:
- Add `CALC_ST_IDLE .. `CALC_ST_WB (3-bit encodings) and `CALC_TIMEOUT_DEF to sr_cpu.vh.
- One natural sub-module: sr_calc_watchdog (clear/enable counter with terminal-count output, CNT_W/TIMEOUT params).

Test Plan:
- Stimulus: req a=3, b=4, rd=5; calc model busy 6 cycles, y=24'h000019. Response: calc_start pulses exactly once; stall high 10 cycles; wb_en one cycle with wb_rd=5, wb_data=32'h19.
- Stimulus: same request, rd=0. Response: full sequence runs, wb_en never asserts, stall releases in WB.
- Stimulus: calc_busy never rises, TIMEOUT=8. Response: WB reached 8 cycles after LAUNCH, wb_data=0, err=1, and err stays 1 until rst.
- Stimulus: rst asserted in RUN. Response: next cycle IDLE, stall=0 (req_valid low), no wb_en, err=0.
- Stimulus: two back-to-back requests (a=1, b=2 then a=7, b=9). Response: each gets exactly one calc_start; wb_data matches the respective y; no overlap of RUN phases.
- Stimulus (SR_CALC_MEMO_EN): repeat a=3, b=4. Response: no calc_start; wb_en one cycle after req_valid with 32'h19. After a timeout abort the same request relaunches the calculator.

Source files
------------

// File: rtl/sr_calc_ctrl_pkg.sv
// Shared types for the HYP-class calculator sequencer.
//   calc_state_t     : sequencer state encoding (3 bits)
//   CALC_TIMEOUT_DEF : default watchdog limit in cycles
//   in_flight()      : true while a launched request still holds the PC
package sr_calc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LAUNCH    = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_RUN       = 3'd3,
    ST_WB        = 3'd4
  } calc_state_t;

  localparam int unsigned CALC_TIMEOUT_DEF = 64;

  function automatic logic in_flight(input calc_state_t s);
    return (s != ST_IDLE) && (s != ST_WB);
  endfunction

endpackage

// File: rtl/sr_calc_ctrl_watchdog.sv
// Hang watchdog for the calculator sequencer: a clearable, enabled up-counter
// whose terminal-count flag marks the last cycle a wait may continue.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   i_clr    : synchronous clear (start of a new calculation)
//   i_en     : count this cycle
//   o_tc     : counter has reached TIMEOUT-1
module sr_calc_ctrl_watchdog #(
  parameter int unsigned CNT_W   = 7,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tc = (r_cnt == TC_VAL);

endmodule

// File: rtl/sr_calc_ctrl.sv
// Sequencer between sr_control and the multi-cycle func_calculator.
// Accepts one HYP request at a time, pulses calc_start, stalls the PC while
// the calculator works and issues a one-cycle register-file write-back.
// A watchdog aborts a hung calculation (wb_data=0, sticky err).
// Optional build macro SR_CALC_MEMO_EN: single-entry result memo; a request
// whose operands match the last completed pair goes straight to write-back.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/a/b/rd    : decoded HYP request, held while stall is high
//   stall               : hold PC (combinational)
//   calc_start          : one-cycle start pulse to the calculator
//   calc_a, calc_b      : latched operands
//   calc_busy, calc_y   : calculator busy and result
//   wb_en, wb_rd, wb_data : register-file write-back (x0 never written)
//   err                 : sticky watchdog-abort flag
module sr_calc_ctrl
  import sr_calc_ctrl_pkg::*;
#(
  parameter int unsigned OP_W    = 8,
  parameter int unsigned RES_W   = 24,
  parameter int unsigned TIMEOUT = CALC_TIMEOUT_DEF,
  parameter int unsigned CNT_W   = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [OP_W-1:0]  req_a,
  input  logic [OP_W-1:0]  req_b,
  input  logic [4:0]       req_rd,
  output logic             stall,
  output logic             calc_start,
  output logic [OP_W-1:0]  calc_a,
  output logic [OP_W-1:0]  calc_b,
  input  logic             calc_busy,
  input  logic [RES_W-1:0] calc_y,
  output logic             wb_en,
  output logic [4:0]       wb_rd,
  output logic [31:0]      wb_data,
  output logic             err
);

  calc_state_t r_state;
  logic        r_calc_start;
  logic        r_wb_en;

  logic        w_waiting;
  logic        w_exit;
  logic        w_tc;
  logic        w_abort;
  logic        w_memo_hit;
  logic [31:0] w_memo_data;

  // Exit condition of the current wait: busy rising in WAIT_BUSY, busy
  // falling in RUN.
  always_comb begin
    w_waiting = (r_state == ST_WAIT_BUSY) || (r_state == ST_RUN);
    w_exit    = (r_state == ST_WAIT_BUSY) ? calc_busy : !calc_busy;
    w_abort   = w_waiting && !w_exit && w_tc;
  end

  sr_calc_ctrl_watchdog #(
    .CNT_W  (CNT_W),
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk  (clk),
    .rst  (rst),
    .i_clr(r_state == ST_LAUNCH),
    .i_en (w_waiting && !w_exit),
    .o_tc (w_tc)
  );

`ifdef SR_CALC_MEMO_EN
  logic             r_memo_valid;
  logic [OP_W-1:0]  r_memo_a;
  logic [OP_W-1:0]  r_memo_b;
  logic [RES_W-1:0] r_memo_y;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_memo_valid <= 1'b0;
      r_memo_a     <= '0;
      r_memo_b     <= '0;
      r_memo_y     <= '0;
    end else if (w_abort) begin
      r_memo_valid <= 1'b0;
    end else if ((r_state == ST_RUN) && !calc_busy) begin
      r_memo_valid <= 1'b1;
      r_memo_a     <= calc_a;
      r_memo_b     <= calc_b;
      r_memo_y     <= calc_y;
    end
  end

  assign w_memo_hit  = r_memo_valid && (req_a == r_memo_a) && (req_b == r_memo_b);
  assign w_memo_data = 32'(r_memo_y);
`else
  assign w_memo_hit  = 1'b0;
  assign w_memo_data = '0;
`endif

  // Pulses are registered on the transition into LAUNCH / WB so they line up
  // with the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      calc_a       <= '0;
      calc_b       <= '0;
      wb_rd        <= '0;
      wb_data      <= '0;
      err          <= 1'b0;
      r_calc_start <= 1'b0;
      r_wb_en      <= 1'b0;
    end else begin
      r_calc_start <= 1'b0;
      r_wb_en      <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            if (w_memo_hit) begin
              calc_a  <= req_a;
              calc_b  <= req_b;
              wb_rd   <= req_rd;
              wb_data <= w_memo_data;
              r_wb_en <= (req_rd != '0);
              r_state <= ST_WB;
            end else if (!calc_busy) begin
              // A stale busy from the calculator holds the request here.
              calc_a       <= req_a;
              calc_b       <= req_b;
              wb_rd        <= req_rd;
              r_calc_start <= 1'b1;
              r_state      <= ST_LAUNCH;
            end
          end
        end
        ST_LAUNCH: begin
          r_state <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY, ST_RUN: begin
          if (w_abort) begin
            wb_data <= '0;
            err     <= 1'b1;
            r_wb_en <= (wb_rd != '0);
            r_state <= ST_WB;
          end else if (r_state == ST_WAIT_BUSY) begin
            if (calc_busy) begin
              r_state <= ST_RUN;
            end
          end else if (!calc_busy) begin
            wb_data <= 32'(calc_y);
            r_wb_en <= (wb_rd != '0);
            r_state <= ST_WB;
          end
        end
        ST_WB: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign stall      = ((r_state == ST_IDLE) && req_valid) || in_flight(r_state);
  assign calc_start = r_calc_start;
  assign wb_en      = r_wb_en;

endmodule

// File: tb/tb_sr_calc_ctrl.sv
module tb_sr_calc_ctrl;

  localparam int T    = 8;
  localparam int MAXC = 1024;
`ifdef SR_CALC_MEMO_EN
  localparam bit MEMO = 1'b1;
`else
  localparam bit MEMO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [7:0]  req_a = '0;
  logic [7:0]  req_b = '0;
  logic [4:0]  req_rd = '0;
  logic        stall, calc_start, calc_busy, wb_en, err;
  logic [7:0]  calc_a, calc_b;
  logic [23:0] calc_y;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;
  int n_start = 0, n_stall = 0, n_wb = 0;

  // calculator model: busy for cfg_n cycles starting cfg_d cycles after start
  int          bf = 1 << 30;
  int          bt = -1;
  logic        stale = 1'b0;
  int          cfg_d = 2, cfg_n = 1;
  logic [23:0] cfg_y = '0;

  // per-cycle expectations
  bit        e_stall[MAXC];
  bit        e_start[MAXC];
  bit        e_wb[MAXC];
  bit        e_err[MAXC];
  bit [4:0]  e_rd[MAXC];
  bit [7:0]  e_ca[MAXC];
  bit [7:0]  e_cb[MAXC];
  bit [31:0] e_data[MAXC];

  // reference memo
  bit        m_valid = 1'b0;
  bit [7:0]  m_a, m_b;
  bit [23:0] m_y;

  sr_calc_ctrl #(
    .OP_W   (8),
    .RES_W  (24),
    .TIMEOUT(T),
    .CNT_W  (7)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_rd    (req_rd),
    .stall     (stall),
    .calc_start(calc_start),
    .calc_a    (calc_a),
    .calc_b    (calc_b),
    .calc_busy (calc_busy),
    .calc_y    (calc_y),
    .wb_en     (wb_en),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rst) begin
      bf <= 1 << 30;
      bt <= -1;
    end else if (calc_start) begin
      bf <= cyc + cfg_d;
      bt <= cyc + cfg_d + cfg_n - 1;
    end
  end

  assign calc_busy = stale | ((cyc >= bf) && (cyc <= bt));
  assign calc_y    = (cyc > bt) ? cfg_y : 24'hBADBAD;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      if (cyc >= MAXC) begin
        chk("cycle_budget", cyc, MAXC - 1);
      end else begin
        chk("stall", stall, e_stall[cyc]);
        chk("calc_start", calc_start, e_start[cyc]);
        if (e_start[cyc]) begin
          chk("calc_a", calc_a, e_ca[cyc]);
          chk("calc_b", calc_b, e_cb[cyc]);
        end
        chk("wb_en", wb_en, e_wb[cyc]);
        if (e_wb[cyc]) chk("wb_rd", wb_rd, e_rd[cyc]);
        chk("wb_data", wb_data, e_data[cyc]);
        chk("err", err, e_err[cyc]);
      end
      if (calc_start) n_start++;
      if (stall) n_stall++;
      if (wb_en) n_wb++;
    end
  end

  // Outcome of one launched request from the watchdog rules: the counter
  // starts at 0 after LAUNCH, counts every waiting cycle that does not exit,
  // and aborts when it reads T-1 on a non-exit cycle. off = LAUNCH->WB cycles.
  function automatic void outcome(input int d, input int n, output int off, output bit abort);
    if (n == 0 || d > T) begin
      abort = 1'b1;
      off   = T + 1;
    end else if (n >= T + 2 - d) begin
      abort = 1'b1;
      off   = T + 2;
    end else begin
      abort = 1'b0;
      off   = d + n + 1;
    end
  endfunction

  task automatic set_data(input int from, input bit [31:0] v);
    for (int i = from; i < MAXC; i++) e_data[i] = v;
  endtask

  task automatic set_err(input int from, input bit v);
    for (int i = from; i < MAXC; i++) e_err[i] = v;
  endtask

  task automatic plan(input bit [7:0] a, input bit [7:0] b, input bit [4:0] rd,
                      input int d, input int n, input bit [23:0] y, input int h,
                      output int wb);
    int c0, L, off;
    bit abort, hit;
    c0  = cyc;
    hit = MEMO && m_valid && (m_a == a) && (m_b == b);
    if (hit) begin
      wb = c0 + 1;
      e_stall[c0] = 1'b1;
      set_data(wb, {8'h00, m_y});
    end else begin
      outcome(d, n, off, abort);
      L  = c0 + h + 1;
      wb = L + off;
      for (int i = c0; i < wb; i++) e_stall[i] = 1'b1;
      e_start[L] = 1'b1;
      e_ca[L]    = a;
      e_cb[L]    = b;
      if (abort) begin
        set_data(wb, 32'h0);
        set_err(wb, 1'b1);
        m_valid = 1'b0;
      end else begin
        set_data(wb, {8'h00, y});
        m_valid = 1'b1;
        m_a = a;
        m_b = b;
        m_y = y;
      end
    end
    e_wb[wb] = (rd != 5'd0);
    e_rd[wb] = rd;
    cfg_d = d;
    cfg_n = n;
    cfg_y = y;
  endtask

  task automatic do_req(input bit [7:0] a, input bit [7:0] b, input bit [4:0] rd,
                        input int d, input int n, input bit [23:0] y, input int h,
                        output int c0, output int wb);
    c0 = cyc;
    plan(a, b, rd, d, n, y, h, wb);
    req_a = a;
    req_b = b;
    req_rd = rd;
    req_valid = 1'b1;
    stale = (h > 0);
    for (int i = 0; i < h; i++) begin
      @(posedge clk); #1;
    end
    stale = 1'b0;
    while (cyc <= wb) begin
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL sim_timeout cycle=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int c0, wb, s0, st0, w0, r;
    rst = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    chk("reset_stall", stall, 0);
    chk("reset_wb_data", wb_data, 0);
    chk("reset_err", err, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // nominal: busy 6 cycles
    s0 = n_start; st0 = n_stall; w0 = n_wb;
    do_req(8'd3, 8'd4, 5'd5, 2, 6, 24'h000019, 0, c0, wb);
    chk("t1_start_cnt", n_start - s0, 1);
    chk("t1_stall_cnt", n_stall - st0, 10);
    chk("t1_wb_cnt", n_wb - w0, 1);
    chk("t1_latency", wb - c0, 10);
    chk("t1_wb_data", wb_data, 32'h19);

    do_req(8'd3, 8'd4, 5'd5, 2, 6, 24'h000019, 0, c0, wb);

    // rd = x0: no write enable
    w0 = n_wb;
    do_req(8'd3, 8'd4, 5'd0, 2, 6, 24'h000019, 0, c0, wb);
    chk("t3_wb_cnt_x0", n_wb - w0, 0);

    // longest busy that still completes under T=8
    do_req(8'd10, 8'd11, 5'd7, 2, 7, 24'h00006e, 0, c0, wb);
    chk("t4_latency", wb - c0, 11);
    chk("t4_err", err, 0);

    // busy high for one cycle only, rising right after start
    do_req(8'd5, 8'd6, 5'd3, 1, 1, 24'h00001e, 0, c0, wb);

    // stale busy in IDLE holds the launch for 3 cycles
    do_req(8'd2, 8'd8, 5'd9, 2, 3, 24'h000010, 3, c0, wb);

    // back-to-back requests
    s0 = n_start;
    do_req(8'd1, 8'd2, 5'd4, 2, 4, 24'h000002, 0, c0, wb);
    do_req(8'd7, 8'd9, 5'd6, 2, 5, 24'h00003f, 0, c0, wb);
    chk("t7_start_cnt", n_start - s0, 2);
    chk("t7_wb_data", wb_data, 32'h3f);

    do_req(8'd3, 8'd4, 5'd5, 2, 6, 24'h000019, 0, c0, wb);

    // calculator never goes busy: abort in WAIT_BUSY
    do_req(8'h30, 8'h01, 5'd10, 2, 0, 24'h000077, 0, c0, wb);
    chk("t9_latency", wb - c0, 10);
    chk("t9_wb_data", wb_data, 32'h0);
    chk("t9_err", err, 1);

    // same request relaunches after the abort; err stays set
    s0 = n_start;
    do_req(8'd3, 8'd4, 5'd5, 2, 6, 24'h000019, 0, c0, wb);
    chk("t10_start_cnt", n_start - s0, 1);
    chk("t10_err_sticky", err, 1);

    // busy one cycle too long: abort in RUN
    do_req(8'h20, 8'h21, 5'd8, 2, 8, 24'h000055, 0, c0, wb);
    chk("t11_latency", wb - c0, 11);
    chk("t11_wb_data", wb_data, 32'h0);

    // reset while in RUN
    w0 = n_wb;
    plan(8'h40, 8'h41, 5'd11, 2, 20, 24'h000033, 0, wb);
    req_a = 8'h40;
    req_b = 8'h41;
    req_rd = 5'd11;
    req_valid = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
    end
    r = cyc;
    req_valid = 1'b0;
    rst = 1'b1;
    for (int i = r + 1; i < MAXC; i++) begin
      e_stall[i] = 1'b0;
      e_start[i] = 1'b0;
      e_wb[i]    = 1'b0;
      e_err[i]   = 1'b0;
      e_data[i]  = 32'h0;
    end
    m_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t12_stall", stall, 0);
    chk("t12_err", err, 0);
    chk("t12_wb_en", wb_en, 0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("t12_no_wb", n_wb - w0, 0);

    s0 = n_start;
    do_req(8'd3, 8'd4, 5'd5, 2, 6, 24'h000019, 0, c0, wb);
    chk("t13_start_cnt", n_start - s0, 1);
    chk("t13_wb_data", wb_data, 32'h19);

    repeat (3) begin
      @(posedge clk); #1;
    end
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
